// File: rtl/fp_addsub_norm_seq_if.sv
// Operand/result handshake bundle for the FP add/sub normaliser-rounder.
// master drives operands and out_ready; slave is the normaliser itself.
interface fp_addsub_norm_seq_if #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 52,
  parameter int DATA_WIDTH = 64
);
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_WIDTH-1:0]    in_Exp;
  logic [MANT_WIDTH+5:0]   in_Mant;
  logic [1:0]              in_Round;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_result;
  logic                    out_flag_OF;
  logic                    out_flag_UF;
  logic                    out_flag_NX;

  modport master (
    output in_valid, in_Exp, in_Mant, in_Round, out_ready,
    input  in_ready, out_valid, out_result, out_flag_OF, out_flag_UF, out_flag_NX
  );

  modport slave (
    input  in_valid, in_Exp, in_Mant, in_Round, out_ready,
    output in_ready, out_valid, out_result, out_flag_OF, out_flag_UF, out_flag_NX
  );
endinterface

// File: rtl/fp_addsub_norm_seq.sv
// Sequential normaliser/rounder placed after the aligned mantissa adder: magnitude,
// iterative bounded left shift, IEEE rounding and packing with OF/UF/NX flags.
module fp_addsub_norm_seq #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 52,
  parameter int DATA_WIDTH = 64,
  parameter int SHIFT_STEP = 8
) (
  input logic               in_clk,
  input logic               in_rst_n,
  fp_addsub_norm_seq_if.slave bus
);
  localparam int EW = EXP_WIDTH;
  localparam int MW = MANT_WIDTH;
  localparam int XW = EXP_WIDTH + 2;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  localparam logic [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic [XW-1:0] EXP_ALL1 = {2'b00, {EW{1'b1}}};

  if (DATA_WIDTH != 1 + EXP_WIDTH + MANT_WIDTH) begin : gBadWidth
    $error("DATA_WIDTH must equal 1+EXP_WIDTH+MANT_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    SHIFT,
    ROUND,
    DONE
  } state_e;

  state_e              state_q;
  logic                prepPhase_q;
  logic [MW+5:0]       raw_q;
  logic [MW+4:0]       mag_q;
  logic [XW-1:0]       exp_q;
  logic                sign_q;
  logic [1:0]          round_q;
  logic                inReady_q;
  logic                outValid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                of_q;
  logic                uf_q;
  logic                nx_q;

  logic [MW+4:0]       negMag_d;
  logic [MW+4:0]       prepMag_d;
  logic [XW-1:0]       prepExp_d;
  logic [31:0]         lzCnt;
  logic [31:0]         shAmt;
  logic [31:0]         shLimit;
  logic [MW+2:0]       shUpper;
  logic [MW+4:0]       shMag_d;
  logic [XW-1:0]       shExp_d;
  logic                rInexact;
  logic                rInc;
  logic [MW+1:0]       rSum;
  logic [XW-1:0]       rExp;
  logic                rHidden;
  logic [MW-1:0]       rFrac;
  logic [EW-1:0]       rExpField;
  logic                rOvf;
  logic                rToInf;
  logic [DATA_WIDTH-1:0] rResult;
  logic                rUf;
  logic                rNx;

  // Negation is registered on its own, so the wide carry chain and the carry/zero decision sit in separate cycles
  always_comb begin
    negMag_d = raw_q[MW+5] ? (~raw_q[MW+4:0] + (MW+5)'(1)) : raw_q[MW+4:0];
    prepMag_d = mag_q;
    prepExp_d = exp_q;
    if (mag_q[MW+4]) begin
      prepMag_d = {1'b0, mag_q[MW+4:2], mag_q[1] | mag_q[0]};
      prepExp_d = exp_q + EXP_ONE;
    end
  end

  // Leading zeros are counted from the hidden bit down through R; S never moves
  always_comb begin
    lzCnt = 32'(MW + 3);
    for (int i = 0; i < MW + 3; i++) begin
      if (mag_q[1+i]) lzCnt = 32'(MW + 2 - i);
    end
    shLimit = 32'(exp_q) - 32'd1;
    shAmt   = lzCnt;
    if (shAmt > 32'(SHIFT_STEP)) shAmt = 32'(SHIFT_STEP);
    if (shAmt > shLimit) shAmt = shLimit;
    shUpper = mag_q[MW+3:1] << shAmt;
    shMag_d = {1'b0, shUpper, mag_q[0]};
    shExp_d = exp_q - XW'(shAmt);
  end

  always_comb begin
    rInexact = mag_q[2] | mag_q[1] | mag_q[0];
    rInc     = 1'b0;
    case (round_q)
      RNE:     rInc = mag_q[2] & (mag_q[1] | mag_q[0] | mag_q[3]);
      RTZ:     rInc = 1'b0;
      RUP:     rInc = ~sign_q & rInexact;
      default: rInc = sign_q & rInexact;
    endcase
    rSum    = {1'b0, mag_q[MW+3:3]} + {{(MW+1){1'b0}}, rInc};
    rExp    = exp_q;
    rHidden = rSum[MW];
    rFrac   = rSum[MW-1:0];
    if (rSum[MW+1]) begin
      rExp    = exp_q + EXP_ONE;
      rHidden = 1'b1;
      rFrac   = '0;
    end
    rExpField = rHidden ? rExp[EW-1:0] : '0;
    rOvf      = rHidden && (rExp >= EXP_ALL1);
    rToInf    = (round_q == RNE) || ((round_q == RUP) && !sign_q) ||
                ((round_q == RDN) && sign_q);
    if (rOvf) begin
      rResult = rToInf ? {sign_q, {EW{1'b1}}, {MW{1'b0}}}
                       : {sign_q, {{(EW-1){1'b1}}, 1'b0}, {MW{1'b1}}};
    end else begin
      rResult = {sign_q, rExpField, rFrac};
    end
    rUf = !rOvf && (rExpField == '0);
    rNx = rInexact | rOvf;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= IDLE;
      prepPhase_q <= 1'b0;
      raw_q       <= '0;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      round_q     <= RNE;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      result_q    <= '0;
      of_q        <= 1'b0;
      uf_q        <= 1'b0;
      nx_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            raw_q       <= bus.in_Mant;
            round_q     <= bus.in_Round;
            exp_q       <= (bus.in_Exp == '0) ? EXP_ONE : {2'b00, bus.in_Exp};
            prepPhase_q <= 1'b0;
            inReady_q   <= 1'b0;
            state_q     <= PREP;
          end
        end
        PREP: begin
          if (!prepPhase_q) begin
            sign_q      <= raw_q[MW+5];
            mag_q       <= negMag_d;
            prepPhase_q <= 1'b1;
          end else if (mag_q == '0) begin
            result_q   <= {(round_q == RDN), {(DATA_WIDTH-1){1'b0}}};
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
            nx_q       <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            mag_q <= prepMag_d;
            exp_q <= prepExp_d;
            if (!prepMag_d[MW+3] && (prepExp_d > EXP_ONE)) state_q <= SHIFT;
            else                                            state_q <= ROUND;
          end
        end
        SHIFT: begin
          mag_q <= shMag_d;
          exp_q <= shExp_d;
          if (shMag_d[MW+3] || (shExp_d == EXP_ONE)) state_q <= ROUND;
        end
        ROUND: begin
          result_q   <= rResult;
          of_q       <= rOvf;
          uf_q       <= rUf;
          nx_q       <= rNx;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.out_valid   = outValid_q;
  assign bus.out_result  = result_q;
  assign bus.out_flag_OF = of_q;
  assign bus.out_flag_UF = uf_q;
  assign bus.out_flag_NX = nx_q;
endmodule

// File: tb/tb_fp_addsub_norm_seq.sv
// Directed-vector bench for fp_addsub_norm_seq: table of hand-computed results,
// plus back-pressure hold and mid-operation reset sequences.
module tb_fp_addsub_norm_seq;
  localparam int EW = 11;
  localparam int MW = 52;
  localparam int DW = 64;
  localparam int NV = 20;

  typedef struct {
    logic [EW-1:0]   exp;
    logic [MW+5:0]   mant;
    logic [1:0]      rnd;
    logic [DW-1:0]   res;
    logic            of;
    logic            uf;
    logic            nx;
    int              lat;
  } vec_t;

  logic in_clk = 1'b0;
  logic in_rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  vec_t vecs[NV];

  fp_addsub_norm_seq_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MW), .DATA_WIDTH(DW)) bus ();

  fp_addsub_norm_seq #(
    .EXP_WIDTH(EW), .MANT_WIDTH(MW), .DATA_WIDTH(DW), .SHIFT_STEP(8)
  ) dut (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .bus     (bus)
  );

  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input int id, input string what,
                             input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL case %0d %s: got %h, expected %h", id, what, act, expv);
    end
  endtask

  task automatic setVec(input int i, input logic [EW-1:0] e, input logic [MW+5:0] m,
                        input logic [1:0] r, input logic [DW-1:0] res,
                        input logic of, input logic uf, input logic nx, input int lat);
    vecs[i].exp = e;  vecs[i].mant = m; vecs[i].rnd = r; vecs[i].res = res;
    vecs[i].of = of;  vecs[i].uf = uf;  vecs[i].nx = nx; vecs[i].lat = lat;
  endtask

  // Drives one operand, then counts edges after acceptance until out_valid (bounded)
  task automatic applyStimulus(input logic [EW-1:0] e, input logic [MW+5:0] m,
                               input logic [1:0] r, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge in_clk); #1; guard++;
    end
    bus.in_Exp = e; bus.in_Mant = m; bus.in_Round = r; bus.in_valid = 1'b1;
    @(posedge in_clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(posedge in_clk); #1; lat++;
    end
  endtask

  task automatic releaseResult();
    bus.out_ready = 1'b1;
    @(posedge in_clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [MW+5:0] one;
    logic [MW+5:0] mRnd;
    int lat;
    bit sawValid;
    one = 1;
    mRnd = (one << 55) | (one << 3) | 4;

    setVec(0,  11'h3FF, one << 55, 2'd0, 64'h3FF0000000000000, 0, 0, 0, 3);
    setVec(1,  11'h3FF, one << 56, 2'd0, 64'h4000000000000000, 0, 0, 0, 3);
    setVec(2,  11'h7FE, one << 56, 2'd0, 64'h7FF0000000000000, 1, 0, 1, 3);
    setVec(3,  11'h7FE, one << 56, 2'd1, 64'h7FEFFFFFFFFFFFFF, 1, 0, 1, 3);
    setVec(4,  11'h3FF, one << 3,  2'd0, 64'h3CB0000000000000, 0, 0, 0, 10);
    setVec(5,  11'h010, one << 3,  2'd0, 64'h0000000000008000, 0, 1, 0, 5);
    setVec(6,  11'h3FF, '0 - (one << 55), 2'd0, 64'hBFF0000000000000, 0, 0, 0, 3);
    setVec(7,  11'h3FF, '0, 2'd3, 64'h8000000000000000, 0, 0, 0, 2);
    setVec(8,  11'h3FF, '0, 2'd0, 64'h0000000000000000, 0, 0, 0, 2);
    setVec(9,  11'h3FF, mRnd, 2'd0, 64'h3FF0000000000002, 0, 0, 1, 3);
    setVec(10, 11'h3FF, mRnd, 2'd1, 64'h3FF0000000000001, 0, 0, 1, 3);
    setVec(11, 11'h3FF, mRnd, 2'd2, 64'h3FF0000000000002, 0, 0, 1, 3);
    setVec(12, 11'h3FF, mRnd, 2'd3, 64'h3FF0000000000001, 0, 0, 1, 3);
    setVec(13, 11'h3FF, '0 - mRnd, 2'd3, 64'hBFF0000000000002, 0, 0, 1, 3);
    setVec(14, 11'h3FF, '0 - mRnd, 2'd2, 64'hBFF0000000000001, 0, 0, 1, 3);
    setVec(15, 11'h3FF, ((one << 56) - 8) | 4, 2'd0, 64'h4000000000000000, 0, 0, 1, 3);
    setVec(16, 11'h7FE, '0 - (one << 56), 2'd2, 64'hFFEFFFFFFFFFFFFF, 1, 0, 1, 3);
    setVec(17, 11'h3FF, (one << 55) | 4, 2'd0, 64'h3FF0000000000000, 0, 0, 1, 3);
    setVec(18, 11'h000, one << 55, 2'd0, 64'h0010000000000000, 0, 0, 0, 3);
    setVec(19, 11'h7FE, '0 - (one << 56), 2'd3, 64'hFFF0000000000000, 1, 0, 1, 3);

    bus.in_valid = 1'b0; bus.in_Exp = '0; bus.in_Mant = '0; bus.in_Round = '0;
    bus.out_ready = 1'b0;
    #12;
    checkOutput(-1, "reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput(-1, "reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput(-1, "reset out_result", bus.out_result, 64'd0);
    checkOutput(-1, "reset flags", {61'd0, bus.out_flag_OF, bus.out_flag_UF, bus.out_flag_NX}, 64'd0);
    @(negedge in_clk); in_rst_n = 1'b1;
    @(posedge in_clk); #1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].exp, vecs[i].mant, vecs[i].rnd, lat);
      checkOutput(i, "latency", 64'(lat), 64'(vecs[i].lat));
      checkOutput(i, "out_result", bus.out_result, vecs[i].res);
      checkOutput(i, "OF", 64'(bus.out_flag_OF), 64'(vecs[i].of));
      checkOutput(i, "UF", 64'(bus.out_flag_UF), 64'(vecs[i].uf));
      checkOutput(i, "NX", 64'(bus.out_flag_NX), 64'(vecs[i].nx));
      releaseResult();
      checkOutput(i, "out_valid after transfer", 64'(bus.out_valid), 64'd0);
      checkOutput(i, "in_ready after transfer", 64'(bus.in_ready), 64'd1);
    end

    // Back-pressure: result and flags must hold while out_ready stays low
    applyStimulus(11'h3FF, mRnd, 2'd0, lat);
    for (int c = 0; c < 5; c++) begin
      checkOutput(100 + c, "hold out_result", bus.out_result, 64'h3FF0000000000002);
      checkOutput(100 + c, "hold NX", 64'(bus.out_flag_NX), 64'd1);
      checkOutput(100 + c, "hold out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput(100 + c, "hold in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge in_clk); #1;
    end
    releaseResult();

    // Reset while SHIFT is iterating: the aborted operand never produces a result
    bus.in_Exp = 11'h3FF; bus.in_Mant = one << 3; bus.in_Round = 2'd0; bus.in_valid = 1'b1;
    @(posedge in_clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin @(posedge in_clk); #1; end
    in_rst_n = 1'b0;
    #1;
    checkOutput(200, "abort out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput(200, "abort in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput(200, "abort out_result", bus.out_result, 64'd0);
    repeat (2) @(posedge in_clk);
    @(negedge in_clk); in_rst_n = 1'b1;
    sawValid = 0;
    repeat (15) begin
      @(posedge in_clk); #1;
      if (bus.out_valid) sawValid = 1;
    end
    checkOutput(201, "no result after abort", 64'(sawValid), 64'd0);

    applyStimulus(11'h3FF, one << 55, 2'd0, lat);
    checkOutput(202, "post-abort latency", 64'(lat), 64'd3);
    checkOutput(202, "post-abort out_result", bus.out_result, 64'h3FF0000000000000);
    checkOutput(202, "post-abort flags",
                {61'd0, bus.out_flag_OF, bus.out_flag_UF, bus.out_flag_NX}, 64'd0);
    releaseResult();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fp_addsub_norm_seq.md
# fp_addsub_norm_seq

Sequential, parametrised normaliser/rounder for the floating-point add/sub datapath. It sits after the aligned mantissa adder in FP_AddSub. It takes a two's-complement sum with carry, hidden, guard, round and sticky bits, then:
- takes the magnitude;
- normalises iteratively, with a bounded left shift per cycle;
- rounds in one of four IEEE modes;
- packs the result with overflow, underflow and inexact flags.

Both sides use a valid/ready handshake.

## Interface
- EXP_WIDTH, 11, exponent field width
- MANT_WIDTH, 52, stored fraction width
- DATA_WIDTH, 64, packed result width; must equal 1+EXP_WIDTH+MANT_WIDTH
- SHIFT_STEP, 8, maximum left-shift positions per SHIFT cycle (1..MANT_WIDTH)
- in_clk  input  1  clock; all state changes on its rising edge
- in_rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_Exp  input  EXP_WIDTH  biased exponent of the larger operand (0 = denormal scale)
- in_Mant  input  MANT_WIDTH+6  two's-complement sum; bit layout:
  - bit [MW+5]: sign
  - bit [MW+4]: carry
  - bit [MW+3]: hidden bit
  - bits [MW+2:3]: fraction
  - bit [2]: guard G
  - bit [1]: round R
  - bit [0]: sticky S
- in_Round  input  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  DATA_WIDTH  {sign, exponent, fraction}
- out_flag_OF  output  1  overflow
- out_flag_UF  output  1  underflow (result denormal or zero from a nonzero sum)
- out_flag_NX  output  1  inexact

## Operation
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture in_Exp, in_Mant, in_Round, then go to PREP.
  - PREP:
    - sign = in_Mant MSB; magnitude = true two's-complement negation if sign=1.
    - E = max(in_Exp,1), held internally as EXP_WIDTH+2 bits.
    - If carry=1: shift right 1, E+1, new G=old LSB, R=old G, S=old R|S.
    - Magnitude zero: force result +0 (sign 0, or 1 only when in_Round=RDN), go to DONE.
    - Else go to SHIFT if the hidden bit is clear and E>1, otherwise ROUND.
  - SHIFT:
    - Each cycle shift left n = min(leading zeros above hidden, SHIFT_STEP, E-1); E -= n.
    - G/R shift into the fraction; S stays sticky.
    - Go to ROUND when the hidden bit is set or E==1.
  - ROUND:
    - L = fraction LSB; inexact = G|R|S.
    - Increment when:
      - RNE: G&(R|S|L)
      - RTZ: never
      - RUP: !sign & inexact
      - RDN: sign & inexact
    - Increment carry out of the hidden bit: mantissa = 1.000…, E+1.
    - Hidden bit still clear: exponent field 0 (denormal).
    - E ≥ 2^EXP_WIDTH−1: overflow.
      - Result is inf (exp all ones, fraction 0) for RNE; for RUP when positive; for RDN when negative.
      - Otherwise result is max finite (exp 2^EXP_WIDTH−2, fraction all ones).
      - OF=1, NX=1.
    - UF = result exponent field 0 and the sum was nonzero. NX = inexact|OF.
    - Go to DONE.
  - DONE: out_valid=1. Outputs are stable while out_ready=0. On out_ready, go to IDLE.
- Outputs are registered; out_result and flags change only when entering DONE.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, all flags 0, in_ready 1.
- Reset asserted mid-operation aborts immediately. No result is emitted for the aborted operand.
- Operand accepted at edge T. Let k = number of SHIFT cycles = ceil(shift distance / SHIFT_STEP), or 0.
  - out_valid rises after edge T+3+k (PREP, k×SHIFT, ROUND).
  - The result transfers on the first edge with out_valid & out_ready.
- in_ready=0 from T until the result has transferred. There is no overlap between operands.
- in_valid with in_ready=0 is ignored. The upstream holds it.
- Cancellation to exact zero skips SHIFT and ROUND. out_valid rises after edge T+2.

## Test plan
- Defaults, RNE, in_Exp=0x3FF, in_Mant=2^55 -> out_result 0x3FF0000000000000, flags 0, out_valid 3 cycles after accept.
- in_Exp=0x3FF, in_Mant=2^56 (carry) -> 0x4000000000000000. Same in_Mant with in_Exp=0x7FE:
  - RNE -> 0x7FF0000000000000, OF=1, NX=1
  - RTZ -> 0x7FEFFFFFFFFFFFFF, OF=1
- in_Exp=0x3FF, in_Mant=2^3 (52-position cancellation) -> 0x3CB0000000000000, k=7, out_valid after edge T+10. Same with in_Exp=0x010 -> denormal, exponent field 0, UF=1.
- in_Mant=−2^55 (58-bit two's complement), in_Exp=0x3FF -> 0xBFF0000000000000. in_Mant=0 with in_Round=RDN -> 0x8000000000000000.
- in_Mant=2^55|2^3|0b100, in_Exp=0x3FF:
  - RNE -> 0x3FF0000000000002, NX=1
  - RTZ -> 0x3FF0000000000001, NX=1
- Hold out_ready=0 for 5 cycles: out_result and flags stay stable, in_ready stays 0. Assert in_rst_n low during SHIFT: out_valid never rises for that operand. The next operand completes correctly.
